// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: single-cycle word memory slave with byte-lane writes and power-up clear
module dmem_bus_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_re,
   input  logic [3:0]  bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_rvalid,
   output logic        bus_err,
   output logic        init_busy
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
   typedef enum logic {INIT, READY} state_t;
   state_t state, state_nx;
   logic [AW-1:0] ptr;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH_WORDS];
   logic in_range, access, ready;
   always_comb begin
      idx      = AW'((bus_addr - BASE_ADDR) >> 2);
      in_range = bus_addr >= BASE_ADDR && {1'b0, bus_addr} < LIMIT;
      access   = bus_re || |bus_we;
      ready    = state == READY;
      state_nx = state == INIT && ptr == AW'(DEPTH_WORDS - 1) ? READY : state;
   end
   assign init_busy = state == INIT;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ready ? ptr : ptr + AW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         bus_rvalid <= ready && bus_re;
         bus_err    <= access && (!ready || !in_range);
         if (ready && bus_re) bus_rdata <= in_range ? mem[idx] : '0;
      end
   end
   // Read above samples mem before this block's write lands, giving read-first behaviour
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!ready) mem[ptr] <= '0;
         else if (in_range)
            for (int i = 0; i < 4; i++)
               if (bus_we[i]) mem[idx][8*i +: 8] <= bus_wdata[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb_dmem_bus_responder: directed scoreboard bench for dmem_bus_responder
module tb_dmem_bus_responder;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_re = 1'b0;
   logic [3:0]  bus_we = 4'h0;
   logic [31:0] bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        bus_rvalid, bus_err, init_busy;
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {
      logic [31:0] d;
      logic        v;
      logic        e;
   } exp_t;
   exp_t q[$];

   dmem_bus_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
      .bus_err(bus_err), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus_rvalid || bus_err) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: rvalid=%0b err=%0b rdata=%h, expected no output",
                     bus_rvalid, bus_err, bus_rdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rvalid", 32'(bus_rvalid), 32'(e.v));
            chk("err", 32'(bus_err), 32'(e.e));
            if (e.v) chk("rdata", bus_rdata, e.d);
         end
      end
   end

   task automatic acc(input logic re, input logic [3:0] we, input logic [31:0] a,
                      input logic [31:0] wd, input logic outp, input logic ev,
                      input logic ee, input logic [31:0] ed);
      exp_t t;
      bus_re = re;
      bus_we = we;
      bus_addr = a;
      bus_wdata = wd;
      if (outp) begin
         t.d = ed;
         t.v = ev;
         t.e = ee;
         q.push_back(t);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus_re = 1'b0;
      bus_we = 4'h0;
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input int w, input logic [31:0] ed);
      acc(1'b1, 4'h0, BASE + 32'(4 * w), 32'h0, 1'b1, 1'b1, 1'b0, ed);
   endtask

   task automatic wr(input int w, input logic [3:0] we, input logic [31:0] wd);
      acc(1'b0, we, BASE + 32'(4 * w), wd, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic count_busy(input string nm);
      int c = 0;
      while (init_busy && c < 100) begin
         c++;
         @(negedge clk);
      end
      chk(nm, 32'(c), 32'(DEPTH));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_rdata", bus_rdata, 32'h0);
      chk("reset_rvalid", 32'(bus_rvalid), 32'h0);
      chk("reset_err", 32'(bus_err), 32'h0);
      chk("reset_busy", 32'(init_busy), 32'h1);
      rst = 1'b0;
      count_busy("init_busy_cycles");
      for (int w = 0; w < DEPTH; w++) rd(w, 32'h0);
      wr(4, 4'hF, 32'hDEAD_BEEF);
      wr(4, 4'h2, 32'h0000_AA00);
      rd(4, 32'hDEAD_AAEF);
      acc(1'b1, 4'h0, BASE + 32'h13, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_AAEF);
      idle(1);
      chk("rdata_hold", bus_rdata, 32'hDEAD_AAEF);
      wr(5, 4'hF, 32'hCAFE_F00D);
      acc(1'b1, 4'hF, BASE + 32'h14, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
      rd(5, 32'h1234_5678);
      acc(1'b1, 4'h0, BASE + 32'(4 * DEPTH), 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
      acc(1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0);
      acc(1'b0, 4'hF, BASE - 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0);
      for (int w = 0; w < DEPTH; w++)
         rd(w, w == 4 ? 32'hDEAD_AAEF : w == 5 ? 32'h1234_5678 : 32'h0);
      for (int w = 6; w < DEPTH; w++) wr(w, 4'hF, 32'hA5A5_0000 | 32'(w * 17));
      for (int w = 6; w < DEPTH; w++) rd(w, 32'hA5A5_0000 | 32'(w * 17));
      idle(1);
      bus_re = 1'b1;
      bus_addr = BASE + 32'h10;
      rst = 1'b1;
      @(negedge clk);
      chk("reset_drops_read", 32'(bus_rvalid), 32'h0);
      chk("reset_busy_again", 32'(init_busy), 32'h1);
      bus_re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      acc(1'b0, 4'hF, BASE + 32'h10, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 32'h0);
      idle(5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy("init_busy_after_midinit_reset");
      rd(4, 32'h0);
      rd(5, 32'h0);
      for (int w = 6; w < DEPTH; w++) rd(w, 32'h0);
      idle(3);
      chk("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
